// File: rtl/hex_step_counter.sv
// Debounced step / auto-run 4-bit up/down counter driving a hex display decoder.
// Inputs pass a 2-flop synchronizer; all outputs are registered, no backpressure.
module hex_step_counter #(
  parameter int DEBOUNCE = 1000000,
  parameter int PRESCALE = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_step,
  input  logic btn_clr,
  input  logic up,
  input  logic run,
  output logic w,
  output logic x,
  output logic y,
  output logic z,
  output logic tc
);

  localparam int DW = $clog2(DEBOUNCE);
  localparam int PW = $clog2(PRESCALE);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [3:0]    sync1_q, sync2_q;
  logic          btn_step_s, btn_clr_s, up_s, run_s;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          stable_q, stable_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    count_q, count_d;
  logic          tc_q, tc_d;
  logic          step_evt, tick;

  assign {btn_step_s, btn_clr_s, up_s, run_s} = sync2_q;

  always_comb begin
    db_cnt_d = db_cnt_q;
    stable_d = stable_q;
    step_evt = 1'b0;
    if (btn_step_s != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d = btn_step_s;
        db_cnt_d = '0;
        step_evt = btn_step_s;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  always_comb begin
    presc_d = '0;
    tick    = 1'b0;
    if (!btn_clr_s && run_s) begin
      if (presc_q == PS_LAST) begin
        tick = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // A coincident step and tick collapse into one event; clear overrides both.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (btn_clr_s) begin
      count_d = 4'd0;
    end else if (step_evt || tick) begin
      if (up_s) begin
        count_d = count_q + 4'd1;
        tc_d    = (count_q == 4'hF);
      end else begin
        count_d = count_q - 4'd1;
        tc_d    = (count_q == 4'h0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_cnt_q <= '0;
      stable_q <= 1'b0;
      presc_q  <= '0;
      count_q  <= 4'd0;
      tc_q     <= 1'b0;
    end else begin
      sync1_q  <= {btn_step, btn_clr, up, run};
      sync2_q  <= sync1_q;
      db_cnt_q <= db_cnt_d;
      stable_q <= stable_d;
      presc_q  <= presc_d;
      count_q  <= count_d;
      tc_q     <= tc_d;
    end
  end

  assign {w, x, y, z} = count_q;
  assign tc = tc_q;

endmodule

// File: tb/tb_hex_step_counter.sv
// Directed bench for hex_step_counter with DEBOUNCE=3, PRESCALE=4.
module tb_hex_step_counter;

  logic clk = 1'b0;
  logic rst_n, btn_step, btn_clr, up, run;
  logic w, x, y, z, tc;
  logic [3:0] wxyz;
  int checks = 0;
  int errors = 0;

  assign wxyz = {w, x, y, z};

  hex_step_counter #(.DEBOUNCE(3), .PRESCALE(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_step (btn_step),
    .btn_clr  (btn_clr),
    .up       (up),
    .run      (run),
    .w        (w),
    .x        (x),
    .y        (y),
    .z        (z),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; btn_step = 1'b0; btn_clr = 1'b0; up = 1'b0; run = 1'b0;
    clk_n(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset dominates active step and run inputs
    rst_n = 1'b0; btn_step = 1'b1; btn_clr = 1'b0; up = 1'b1; run = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      clk_n(1);
      check("rst_cnt", 8'(wxyz), 8'h0);
      check("rst_tc", 8'(tc), 8'h0);
    end
    rst_n = 1'b1;
    clk_n(1);
    check("rst_rel_cnt", 8'(wxyz), 8'h0);
    check("rst_rel_tc", 8'(tc), 8'h0);

    // Held step: one increment at edge 5, then bounces rejected
    do_reset();
    up = 1'b1; btn_step = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      clk_n(1);
      check("step_hold", 8'(wxyz), (e >= 5) ? 8'h1 : 8'h0);
    end
    btn_step = 1'b0;
    clk_n(2);
    check("step_e14", 8'(wxyz), 8'h1);
    clk_n(4);
    repeat (4) begin
      btn_step = 1'b1;
      clk_n(2);
      btn_step = 1'b0;
      clk_n(1);
      check("bounce", 8'(wxyz), 8'h1);
    end
    clk_n(6);
    check("bounce_end", 8'(wxyz), 8'h1);
    up = 1'b0;
    clk_n(4);
    check("dir_toggle", 8'(wxyz), 8'h1);

    // Auto-run down from zero
    do_reset();
    run = 1'b1; up = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      clk_n(1);
      check("run_dn_cnt", 8'(wxyz),
            (e < 6) ? 8'h0 : (e < 10) ? 8'hF : (e < 14) ? 8'hE : 8'hD);
      check("run_dn_tc", 8'(tc), (e == 6) ? 8'h1 : 8'h0);
    end

    // Down-step to 1111, then up-step wraps to 0000
    do_reset();
    up = 1'b0; btn_step = 1'b1;
    clk_n(5);
    check("dn_wrap_cnt", 8'(wxyz), 8'hF);
    check("dn_wrap_tc", 8'(tc), 8'h1);
    btn_step = 1'b0;
    clk_n(8);
    check("pre_up_tc", 8'(tc), 8'h0);
    up = 1'b1; btn_step = 1'b1;
    clk_n(4);
    check("up_wrap_pre", 8'(wxyz), 8'hF);
    check("up_wrap_pre_tc", 8'(tc), 8'h0);
    clk_n(1);
    check("up_wrap_cnt", 8'(wxyz), 8'h0);
    check("up_wrap_tc", 8'(tc), 8'h1);
    clk_n(1);
    check("up_wrap_tc_end", 8'(tc), 8'h0);
    check("up_wrap_hold", 8'(wxyz), 8'h0);
    btn_step = 1'b0;

    // Clear while running at 0110
    do_reset();
    run = 1'b1; up = 1'b1;
    clk_n(25);
    check("clr_e25", 8'(wxyz), 8'h5);
    clk_n(1);
    check("clr_e26", 8'(wxyz), 8'h6);
    btn_clr = 1'b1;
    clk_n(2);
    check("clr_e28", 8'(wxyz), 8'h6);
    btn_clr = 1'b0;
    clk_n(1);
    check("clr_e29", 8'(wxyz), 8'h0);
    check("clr_e29_tc", 8'(tc), 8'h0);
    clk_n(1);
    check("clr_e30", 8'(wxyz), 8'h0);
    clk_n(3);
    check("clr_e33", 8'(wxyz), 8'h0);
    clk_n(1);
    check("clr_e34", 8'(wxyz), 8'h1);

    // Step event lands on the same edge as a tick at 0011
    do_reset();
    run = 1'b1; up = 1'b1;
    clk_n(13);
    btn_step = 1'b1;
    clk_n(1);
    check("coin_e14", 8'(wxyz), 8'h3);
    clk_n(3);
    check("coin_e17", 8'(wxyz), 8'h3);
    clk_n(1);
    check("coin_e18", 8'(wxyz), 8'h4);
    clk_n(1);
    check("coin_e19", 8'(wxyz), 8'h4);
    btn_step = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
